// File: rtl/dla_pkg.sv
// Shared definitions for the DLA controller slice: FSM encoding and default widths.
package dla_pkg;

  localparam int unsigned ACC_WID_DEF = 48;
  localparam int unsigned CNT_WID     = 8;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    LOAD = 2'd1,
    MAC  = 2'd2,
    OUT  = 2'd3
  } state_e;

  // True when a counter value has reached the configured vector length.
  function automatic logic cnt_done(input logic [CNT_WID-1:0] cnt,
                                    input int unsigned         vec_len);
    return cnt == CNT_WID'(vec_len);
  endfunction

endpackage

// File: rtl/cmp_seq_ctrl.sv
// Sequencing controller for a zero-skipping MAC compute unit: accepts operand
// pairs, skips any pair with a zero operand, feeds nonzero pairs to the external
// compute unit and accumulates returned products into one psum per vector.
module cmp_seq_ctrl
  import dla_pkg::*;
#(
  parameter int unsigned DATA_WID = 16,
  parameter int unsigned VEC_LEN  = 9,
  parameter int unsigned ACC_WID  = ACC_WID_DEF
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_WID-1:0] in_weight,
  input  logic [DATA_WID-1:0] in_pixel,
  output logic [DATA_WID-1:0] cu_weight,
  output logic [DATA_WID-1:0] cu_pixel,
  output logic                cu_wgt_state,
  output logic                cu_ifm_state,
  input  logic [ACC_WID-1:0]  cu_psum,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_WID-1:0]  out_psum,
  output logic [CNT_WID-1:0]  out_skips,
  output logic                busy
);

  state_e               state;
  logic [ACC_WID-1:0]   acc;
  logic [CNT_WID-1:0]   elem_cnt;
  logic [CNT_WID-1:0]   skip_cnt;

  logic                 accept;
  logic                 zero_pair;
  logic [CNT_WID-1:0]   elem_nxt;
  logic [CNT_WID-1:0]   skip_nxt;
  logic                 last_elem;
  logic [ACC_WID-1:0]   acc_sum;

  // Handshake, skip detection and next-count arithmetic shared by the FSM.
  assign accept    = in_valid && in_ready;
  assign zero_pair = (in_weight == '0) || (in_pixel == '0);
  assign elem_nxt  = elem_cnt + CNT_WID'(1);
  assign skip_nxt  = skip_cnt + CNT_WID'(1);
  assign last_elem = cnt_done(elem_nxt, VEC_LEN);
  assign acc_sum   = acc + cu_psum;

  // Controller FSM; every output is a register updated alongside the state.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state        <= ACC;
      acc          <= '0;
      elem_cnt     <= '0;
      skip_cnt     <= '0;
      in_ready     <= 1'b1;
      cu_weight    <= '0;
      cu_pixel     <= '0;
      cu_wgt_state <= 1'b0;
      cu_ifm_state <= 1'b0;
      out_valid    <= 1'b0;
      out_psum     <= '0;
      out_skips    <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            busy <= 1'b1;
            if (zero_pair) begin
              elem_cnt <= elem_nxt;
              skip_cnt <= skip_nxt;
              if (last_elem) begin
                state     <= OUT;
                in_ready  <= 1'b0;
                out_valid <= 1'b1;
                out_psum  <= acc;
                out_skips <= skip_nxt;
              end
            end else begin
              state        <= LOAD;
              in_ready     <= 1'b0;
              cu_weight    <= in_weight;
              cu_pixel     <= in_pixel;
              cu_wgt_state <= 1'b1;
              cu_ifm_state <= 1'b1;
            end
          end
        end
        LOAD: begin
          state <= MAC;
        end
        MAC: begin
          acc          <= acc_sum;
          elem_cnt     <= elem_nxt;
          cu_wgt_state <= 1'b0;
          cu_ifm_state <= 1'b0;
          if (last_elem) begin
            state     <= OUT;
            out_valid <= 1'b1;
            out_psum  <= acc_sum;
            out_skips <= skip_cnt;
          end else begin
            state    <= ACC;
            in_ready <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= ACC;
            acc       <= '0;
            elem_cnt  <= '0;
            skip_cnt  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Testbench for cmp_seq_ctrl with a behavioural compute unit and psum model.
module tb_cmp_seq_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned VL = 4;
  localparam int unsigned AW = 48;

  logic          clock = 1'b0;
  logic          rst   = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_weight = '0;
  logic [DW-1:0] in_pixel  = '0;
  logic [DW-1:0] cu_weight;
  logic [DW-1:0] cu_pixel;
  logic          cu_wgt_state;
  logic          cu_ifm_state;
  logic [AW-1:0] cu_psum;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_psum;
  logic [7:0]    out_skips;
  logic          busy;

  logic          force_en  = 1'b0;
  logic [AW-1:0] force_val = '0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int flag_cnt = 0;
  int ov_rise = -1;
  logic ov_prev = 1'b0;

  // Compute unit stand-in: product of the presented operands, or a forced value.
  assign cu_psum = force_en ? force_val : (AW'(cu_weight) * AW'(cu_pixel));

  cmp_seq_ctrl #(.DATA_WID(DW), .VEC_LEN(VL), .ACC_WID(AW)) dut (
    .clock(clock), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_weight(in_weight), .in_pixel(in_pixel),
    .cu_weight(cu_weight), .cu_pixel(cu_pixel),
    .cu_wgt_state(cu_wgt_state), .cu_ifm_state(cu_ifm_state),
    .cu_psum(cu_psum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_psum(out_psum), .out_skips(out_skips), .busy(busy)
  );

  always #5 clock = ~clock;

  // Advance one cycle and sample just after the edge.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (cu_wgt_state) flag_cnt++;
    tests++;
    if (cu_wgt_state !== cu_ifm_state) begin
      fails++;
      $display("FAIL flag_pair cyc=%0d wgt=%b ifm=%b (must match)", cyc, cu_wgt_state, cu_ifm_state);
    end
    if (out_valid && !ov_prev) ov_rise = cyc;
    ov_prev = out_valid;
  endtask

  // Present one pair after a random idle gap; returns the edge it was accepted on.
  task automatic drive_pair(input logic [DW-1:0] w, input logic [DW-1:0] p,
                            input int max_gap, output int acc_edge);
    int   gap;
    logic rdy;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    for (int i = 0; i < gap; i++) begin
      in_valid  = 1'b0;
      in_weight = DW'($urandom);
      in_pixel  = DW'($urandom);
      step();
    end
    in_valid  = 1'b1;
    in_weight = w;
    in_pixel  = p;
    acc_edge  = -1;
    for (int i = 0; i < 40 && acc_edge < 0; i++) begin
      rdy = in_ready;
      step();
      if (rdy) acc_edge = cyc;
    end
    if (acc_edge < 0) begin
      tests++;
      fails++;
      $display("FAIL handshake_timeout w=%0d p=%0d never accepted", w, p);
    end
    in_valid  = 1'b0;
    in_weight = DW'($urandom);
    in_pixel  = DW'($urandom);
  endtask

  // Wait (bounded) for out_valid.
  task automatic wait_out();
    for (int i = 0; i < 30 && !out_valid; i++) step();
    if (!out_valid) begin
      tests++;
      fails++;
      $display("FAIL out_valid_timeout got=%b want=1", out_valid);
    end
  endtask

  // Drive a full vector and collect first/last accept edges.
  task automatic run_vector(input logic [DW-1:0] w [VL], input logic [DW-1:0] p [VL],
                            input int max_gap, output int first_acc, output int last_acc);
    int e;
    flag_cnt  = 0;
    ov_rise   = -1;
    first_acc = -1;
    last_acc  = -1;
    for (int i = 0; i < int'(VL); i++) begin
      drive_pair(w[i], p[i], max_gap, e);
      if (i == 0) first_acc = e;
      last_acc = e;
    end
    wait_out();
  endtask

  // Pop the psum and confirm return to idle.
  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL consume_idle got valid=%b ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  // Reference: psum of nonzero pairs (mod 2^AW), zero-pair count, nonzero count.
  function automatic void model(input logic [DW-1:0] w [VL], input logic [DW-1:0] p [VL],
                                output logic [AW-1:0] psum, output int skips, output int nz);
    psum  = '0;
    skips = 0;
    nz    = 0;
    for (int i = 0; i < int'(VL); i++) begin
      if (w[i] == '0 || p[i] == '0) skips++;
      else begin
        nz++;
        psum = psum + AW'(w[i]) * AW'(p[i]);
      end
    end
  endfunction

  function automatic logic [DW-1:0] rand_op();
    return ($urandom_range(0, 99) < 35) ? '0 : DW'($urandom);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests++;
    if (out_valid !== 1'b0 || cu_wgt_state !== 1'b0 || cu_ifm_state !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags got valid=%b wgt=%b ifm=%b busy=%b want 0", out_valid, cu_wgt_state, cu_ifm_state, busy);
    end
    tests++;
    if (cu_weight !== '0 || cu_pixel !== '0) begin
      fails++;
      $display("FAIL reset_operands got w=%0h p=%0h want 0", cu_weight, cu_pixel);
    end
    rst = 1'b0;
    step();
    tests++;
    if (in_ready !== 1'b1 || out_psum !== '0 || out_skips !== 8'd0) begin
      fails++;
      $display("FAIL reset_release got ready=%b psum=%0h skips=%0d want 1/0/0", in_ready, out_psum, out_skips);
    end
  endtask

  task automatic test_dense();
    logic [DW-1:0] w [VL];
    logic [DW-1:0] p [VL];
    int fa, la;
    w = '{16'd1, 16'd2, 16'd3, 16'd4};
    p = '{16'd2, 16'd2, 16'd2, 16'd2};
    run_vector(w, p, 0, fa, la);
    tests++;
    if (out_psum !== AW'(20) || out_skips !== 8'd0) begin
      fails++;
      $display("FAIL dense_psum got psum=%0d skips=%0d want 20/0", out_psum, out_skips);
    end
    tests++;
    if (ov_rise - fa != 11) begin
      fails++;
      $display("FAIL dense_latency got %0d edges after accept want 11", ov_rise - fa);
    end
    tests++;
    if (flag_cnt != 8) begin
      fails++;
      $display("FAIL dense_flag_cycles got %0d want 8", flag_cnt);
    end
    tests++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL dense_out_state got ready=%b busy=%b want 0/1", in_ready, busy);
    end
    consume();
  endtask

  task automatic test_sparse();
    logic [DW-1:0] w [VL];
    logic [DW-1:0] p [VL];
    int fa, la;
    w = '{16'd0, 16'd7, 16'd3, 16'd0};
    p = '{16'd5, 16'd0, 16'd3, 16'd0};
    run_vector(w, p, 0, fa, la);
    tests++;
    if (out_psum !== AW'(9) || out_skips !== 8'd3) begin
      fails++;
      $display("FAIL sparse_psum got psum=%0d skips=%0d want 9/3", out_psum, out_skips);
    end
    tests++;
    if (ov_rise - fa != 5) begin
      fails++;
      $display("FAIL sparse_latency got %0d edges after accept want 5", ov_rise - fa);
    end
    tests++;
    if (flag_cnt != 2) begin
      fails++;
      $display("FAIL sparse_flag_cycles got %0d want 2", flag_cnt);
    end
    consume();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w [VL];
    logic [DW-1:0] p [VL];
    logic [AW-1:0] exp_psum;
    int exp_skips, nz, fa, la;
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < int'(VL); i++) begin
        w[i] = rand_op();
        p[i] = rand_op();
      end
      model(w, p, exp_psum, exp_skips, nz);
      run_vector(w, p, 2, fa, la);
      tests++;
      if (out_psum !== exp_psum || out_skips !== 8'(exp_skips)) begin
        fails++;
        $display("FAIL bp_psum v=%0d got psum=%0h skips=%0d want %0h/%0d", v, out_psum, out_skips, exp_psum, exp_skips);
      end
      if (v == 0) begin
        for (int c = 0; c < 5; c++) begin
          in_valid  = 1'b1;
          in_weight = 16'd9;
          in_pixel  = 16'd9;
          step();
          tests++;
          if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_psum !== exp_psum || out_skips !== 8'(exp_skips)) begin
            fails++;
            $display("FAIL bp_hold c=%0d got valid=%b ready=%b psum=%0h skips=%0d want 1/0/%0h/%0d",
                     c, out_valid, in_ready, out_psum, out_skips, exp_psum, exp_skips);
          end
        end
        in_valid = 1'b0;
      end
      consume();
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] w [VL];
    logic [DW-1:0] p [VL];
    logic [AW-1:0] exp_psum;
    int fa, la;
    w = '{16'd1, 16'd0, 16'd1, 16'd0};
    p = '{16'd1, 16'd0, 16'd1, 16'd0};
    force_en  = 1'b1;
    force_val = '1;
    exp_psum  = force_val + force_val;
    run_vector(w, p, 0, fa, la);
    tests++;
    if (out_psum !== exp_psum || out_skips !== 8'd2) begin
      fails++;
      $display("FAIL wrap_psum got psum=%0h skips=%0d want %0h/2", out_psum, out_skips, exp_psum);
    end
    consume();
    force_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w [VL];
    logic [DW-1:0] p [VL];
    int e, fa, la;
    drive_pair(16'd1, 16'd1, 0, e);
    drive_pair(16'd1, 16'd1, 0, e);
    step();
    tests++;
    if (cu_wgt_state !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_precond got wgt=%b busy=%b want 1/1", cu_wgt_state, busy);
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || cu_wgt_state !== 1'b0 || cu_ifm_state !== 1'b0 || busy !== 1'b0 ||
        cu_weight !== '0 || cu_pixel !== '0 || out_psum !== '0 || out_skips !== 8'd0) begin
      fails++;
      $display("FAIL mid_reset_outputs got valid=%b wgt=%b ifm=%b busy=%b w=%0h p=%0h psum=%0h skips=%0d want all 0",
               out_valid, cu_wgt_state, cu_ifm_state, busy, cu_weight, cu_pixel, out_psum, out_skips);
    end
    step();
    step();
    rst = 1'b0;
    step();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_release got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    w = '{16'd1, 16'd1, 16'd1, 16'd1};
    p = '{16'd1, 16'd1, 16'd1, 16'd1};
    run_vector(w, p, 0, fa, la);
    tests++;
    if (out_psum !== AW'(4) || out_skips !== 8'd0) begin
      fails++;
      $display("FAIL mid_next_psum got psum=%0d skips=%0d want 4/0", out_psum, out_skips);
    end
    consume();
  endtask

  task automatic test_random();
    logic [DW-1:0] w [VL];
    logic [DW-1:0] p [VL];
    logic [AW-1:0] exp_psum;
    int exp_skips, nz, fa, la, exp_lat;
    for (int v = 0; v < 12; v++) begin
      for (int i = 0; i < int'(VL); i++) begin
        w[i] = rand_op();
        p[i] = rand_op();
      end
      model(w, p, exp_psum, exp_skips, nz);
      exp_lat = (w[VL-1] == '0 || p[VL-1] == '0) ? 0 : 2;
      run_vector(w, p, 3, fa, la);
      tests++;
      if (out_psum !== exp_psum || out_skips !== 8'(exp_skips)) begin
        fails++;
        $display("FAIL rand_psum v=%0d got psum=%0h skips=%0d want %0h/%0d", v, out_psum, out_skips, exp_psum, exp_skips);
      end
      tests++;
      if (flag_cnt != 2 * nz) begin
        fails++;
        $display("FAIL rand_flag_cycles v=%0d got %0d want %0d", v, flag_cnt, 2 * nz);
      end
      tests++;
      if (ov_rise - la != exp_lat) begin
        fails++;
        $display("FAIL rand_latency v=%0d got %0d want %0d", v, ov_rise - la, exp_lat);
      end
      for (int d = int'($urandom_range(0, 3)); d > 0; d--) step();
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_dense();
    test_sparse();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
